// File: rtl/sonar_sched_if.sv
// Register-slave bundle for sonar_sched: request from the bus decoder, ack and read data back.
interface sonar_sched_if;
  logic        valid_i;
  logic        strb_i;
  logic [1:0]  adr_i;
  logic [15:0] dat_i;
  logic        ack_o;
  logic [15:0] dat_o;

  modport master (
    output valid_i,
    output strb_i,
    output adr_i,
    output dat_i,
    input  ack_o,
    input  dat_o
  );

  modport slave (
    input  valid_i,
    input  strb_i,
    input  adr_i,
    input  dat_i,
    output ack_o,
    output dat_o
  );
endinterface

// File: rtl/sonar_sched.sv
// Round-robin measurement scheduler for the sonar channel array.
// Picks one enabled channel at a time, pulses its accumulator clear, counts a listen
// window in ce_pcm ticks and latches the comparator result into a sticky HIT register.
module sonar_sched #(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned CLR_CYC = 4
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  sonar_sched_if.slave    bus_io,
  input  logic            ce_pcm,
  input  logic [N_CH-1:0] cmp_i,
  output logic [N_CH-1:0] mclear_o,
  output logic [3:0]      ch_sel_o,
  output logic            busy_o,
  output logic            irq_o
);

  localparam int unsigned     ClrW    = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam logic [ClrW-1:0] ClrLast = ClrW'(CLR_CYC - 1);
  localparam logic [3:0]      ChLast  = 4'(N_CH - 1);

  typedef enum logic [2:0] {StIdle, StSelect, StClear, StListen, StLatch} state_e;

  state_e state_q, state_d;

  // Software-visible registers
  logic            run_q, run_d;
  logic            single_q, single_d;
  logic [N_CH-1:0] ch_en_q, ch_en_d;
  logic [15:0]     window_q, window_d;
  logic [N_CH-1:0] hit_q, hit_d;
  logic            ack_q, ack_d;
  logic [15:0]     rdata_q, rdata_d;

  // Measurement datapath
  logic [3:0]      ch_q, ch_d;
  logic [3:0]      ptr_q, ptr_d;
  logic [ClrW-1:0] clr_cnt_q, clr_cnt_d;
  logic [15:0]     tick_q, tick_d;
  logic [15:0]     win_q, win_d;
  logic            flag_q, flag_d;

  logic            acc, wr_en, rd_en;
  logic [N_CH-1:0] ch_oh;
  logic            cmp_sel;
  logic [3:0]      sel_idx;
  logic            sel_found;
  logic            round_end;
  logic            win_end;

  // Channel search: next channel at/after ptr (with wrap), round-end test, one-hot of ch
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 4'd0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (ch_en_q[i] && (i >= int'(ptr_q))) begin
        sel_idx   = 4'(i);
        sel_found = 1'b1;
      end
    end
    if (!sel_found) begin
      for (int i = int'(N_CH) - 1; i >= 0; i--) begin
        if (ch_en_q[i]) begin
          sel_idx = 4'(i);
        end
      end
    end
    round_end = 1'b1;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (ch_en_q[i] && (i > int'(ch_q))) begin
        round_end = 1'b0;
      end
    end
    ch_oh = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      ch_oh[i] = (ch_q == 4'(i));
    end
  end

  assign cmp_sel = |(cmp_i & ch_oh);
  // win_q is never 0, so the count cannot overflow before it matches
  assign win_end = ce_pcm && ((tick_q + 16'd1) >= win_q);

  // FSM state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (run_q && (ch_en_q != '0)) state_d = StSelect;
      end
      StSelect: begin
        state_d = (ch_en_q != '0) ? StClear : StIdle;
      end
      StClear: begin
        if (clr_cnt_q == ClrLast) state_d = StListen;
      end
      StListen: begin
        if (win_end) state_d = StLatch;
      end
      StLatch: begin
        if (round_end && single_q) begin
          state_d = StIdle;
        end else if (run_q) begin
          state_d = StSelect;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: busy and the clear pulse on the selected channel only
  always_comb begin
    busy_o   = (state_q != StIdle);
    mclear_o = (state_q == StClear) ? ch_oh : '0;
  end

  // Measurement datapath next-state
  always_comb begin
    ch_d      = ch_q;
    ptr_d     = ptr_q;
    clr_cnt_d = clr_cnt_q;
    tick_d    = tick_q;
    win_d     = win_q;
    flag_d    = flag_q;
    case (state_q)
      StSelect: begin
        if (ch_en_q != '0) ch_d = sel_idx;
        clr_cnt_d = '0;
      end
      StClear: begin
        clr_cnt_d = clr_cnt_q + ClrW'(1);
        tick_d    = '0;
        flag_d    = 1'b0;
        // WINDOW is sampled here so a change lands on the next measurement
        win_d     = (window_q == 16'd0) ? 16'd1 : window_q;
      end
      StListen: begin
        if (ce_pcm) begin
          tick_d = tick_q + 16'd1;
          flag_d = flag_q | cmp_sel;
        end
      end
      StLatch: begin
        ptr_d = (ch_q == ChLast) ? 4'd0 : ch_q + 4'd1;
      end
      default: ;
    endcase
  end

  // Measurement datapath registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      ch_q      <= 4'd0;
      ptr_q     <= 4'd0;
      clr_cnt_q <= '0;
      tick_q    <= 16'd0;
      win_q     <= 16'd1;
      flag_q    <= 1'b0;
    end else begin
      ch_q      <= ch_d;
      ptr_q     <= ptr_d;
      clr_cnt_q <= clr_cnt_d;
      tick_q    <= tick_d;
      win_q     <= win_d;
      flag_q    <= flag_d;
    end
  end

  // Register file: access decode, W1C on HIT, LATCH set and SINGLE self-clear
  always_comb begin
    acc      = bus_io.valid_i && !ack_q;
    wr_en    = acc && bus_io.strb_i;
    rd_en    = acc && !bus_io.strb_i;
    ack_d    = acc;
    run_d    = run_q;
    single_d = single_q;
    ch_en_d  = ch_en_q;
    window_d = window_q;
    hit_d    = hit_q;
    rdata_d  = rdata_q;
    if (wr_en) begin
      unique case (bus_io.adr_i)
        2'd0: begin
          run_d    = bus_io.dat_i[0];
          single_d = bus_io.dat_i[1];
        end
        2'd1: ch_en_d  = bus_io.dat_i[N_CH-1:0];
        2'd2: window_d = bus_io.dat_i;
        2'd3: hit_d    = hit_q & ~bus_io.dat_i[N_CH-1:0];
      endcase
    end
    if (rd_en) begin
      unique case (bus_io.adr_i)
        2'd0: rdata_d = {14'd0, single_q, run_q};
        2'd1: rdata_d = 16'(ch_en_q);
        2'd2: rdata_d = window_q;
        2'd3: rdata_d = 16'(hit_q);
      endcase
    end
    if (state_q == StLatch) begin
      // Applied after the W1C so a same-cycle set survives
      hit_d = hit_d | (ch_oh & {N_CH{flag_q}});
      if (round_end && single_q) run_d = 1'b0;
    end
  end

  // Register file storage
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      run_q    <= 1'b0;
      single_q <= 1'b0;
      ch_en_q  <= '0;
      window_q <= 16'd1000;
      hit_q    <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= 16'd0;
    end else begin
      run_q    <= run_d;
      single_q <= single_d;
      ch_en_q  <= ch_en_d;
      window_q <= window_d;
      hit_q    <= hit_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus_io.ack_o = ack_q;
  assign bus_io.dat_o = rdata_q;
  assign ch_sel_o     = ch_q;
  assign irq_o        = |hit_q;

endmodule
